// File: rtl/fetch_unit.sv
// fetch_unit: multicycle instruction fetch stage.
// Owns the PC and instruction register and handshakes one instruction-memory read per FETCH state.
//
// Ports:
//   clk, reset       clock; asynchronous active-low reset
//   fetch_en         controller is in FETCH (level)
//   pc_inc           one-cycle pulse: pc += 4
//   jump_en          one-cycle pulse: pc = jump_target with bit 0 cleared (wins over pc_inc)
//   jump_target      jump destination
//   mem_req          read request to instruction memory
//   mem_addr         read address, stable while mem_req is high
//   mem_rdata        read data, valid with mem_ack
//   mem_ack          one-cycle read completion strobe
//   instr            instruction register
//   instr_valid      instr was fetched for the current FETCH state
//   pc               current program counter
//   fetch_busy       combinational stall for the controller clock enable
//   fetch_fault      sticky misaligned-fetch flag
module fetch_unit #(
    parameter int unsigned          XLEN      = 32,
    parameter logic [XLEN-1:0]      RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_en,
    input  logic            pc_inc,
    input  logic            jump_en,
    input  logic [XLEN-1:0] jump_target,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic            fetch_busy,
    output logic            fetch_fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic            mem_req_q, mem_req_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] jump_pc;

    // Jumps land on a halfword boundary; bit 1 can still be set and is
    // caught as a misaligned fetch.
    assign jump_pc = jump_target & ~XLEN'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            fault_q       <= fault_d;
        end
    end

    // PC update runs independently of the fetch FSM; the in-flight
    // request keeps its own copy of the address in mem_addr_q.
    always_comb begin
        pc_d = pc_q;
        if (jump_en) begin
            pc_d = jump_pc;
        end else if (pc_inc) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        fault_d       = fault_q;
        unique case (state_q)
            IDLE: begin
                if (fetch_en) begin
                    if (pc_q[1:0] == 2'b00) begin
                        state_d    = WAIT;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_q;
                    end else begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    state_d       = HOLD;
                    instr_d       = mem_rdata;
                    instr_valid_d = 1'b1;
                    mem_req_d     = 1'b0;
                end
            end
            HOLD: begin
                // One fetch per FETCH state: wait for fetch_en to drop.
                if (!fetch_en) begin
                    state_d       = IDLE;
                    instr_valid_d = 1'b0;
                end
            end
            FAULT: begin
                // Terminal until reset.
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fetch_busy  = ((state_q == IDLE) && fetch_en)
                       || (state_q == WAIT)
                       || (state_q == FAULT);
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit.
// Drives inputs 1ns after each rising edge and checks outputs there.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic        pc_inc;
    logic        jump_en;
    logic [31:0] jump_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic        fetch_busy;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;
    int req_rises = 0;
    int base;
    logic req_prev = 1'b0;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .pc_inc      (pc_inc),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .fetch_busy  (fetch_busy),
        .fetch_fault (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count request launches as rising edges of mem_req.
    always @(posedge clk) begin
        if (mem_req && !req_prev) req_rises <= req_rises + 1;
        req_prev <= mem_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; fetch_en = 1'b0; pc_inc = 1'b0; jump_en = 1'b0;
        jump_target = '0; mem_rdata = '0; mem_ack = 1'b0;
        tick(); tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h13);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_req", {31'b0, mem_req}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
        reset = 1'b1;
        tick();

        // Zero-wait fetch
        base = req_rises;
        fetch_en = 1'b1;
        #1;
        chk("zw_busy1", {31'b0, fetch_busy}, 32'h1);
        tick();
        chk("zw_req", {31'b0, mem_req}, 32'h1);
        chk("zw_addr", mem_addr, 32'h0);
        chk("zw_busy2", {31'b0, fetch_busy}, 32'h1);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0037;
        tick();
        mem_ack = 1'b0;
        chk("zw_busy3", {31'b0, fetch_busy}, 32'h0);
        chk("zw_instr", instr, 32'h37);
        chk("zw_valid", {31'b0, instr_valid}, 32'h1);
        chk("zw_reqlo", {31'b0, mem_req}, 32'h0);
        chk("zw_nreq", req_rises - base, 32'd1);
        fetch_en = 1'b0;
        tick();
        chk("zw_idle_valid", {31'b0, instr_valid}, 32'h0);
        chk("zw_idle_instr", instr, 32'h37);

        // Wait states, with a PC bump mid-request
        pc_inc = 1'b1;
        tick();
        pc_inc = 1'b0;
        chk("ws_pc4", pc, 32'h4);
        base = req_rises;
        fetch_en = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("ws_req", {31'b0, mem_req}, 32'h1);
            chk("ws_addr", mem_addr, 32'h4);
            chk("ws_busy", {31'b0, fetch_busy}, 32'h1);
            pc_inc = (i == 2);
            tick();
        end
        pc_inc = 1'b0;
        chk("ws_pc8", pc, 32'h8);
        chk("ws_addr_kept", mem_addr, 32'h4);
        mem_ack = 1'b1; mem_rdata = 32'h00a0_0093;
        tick();
        mem_ack = 1'b0;
        chk("ws_instr", instr, 32'h00a0_0093);
        chk("ws_valid", {31'b0, instr_valid}, 32'h1);
        chk("ws_busy_lo", {31'b0, fetch_busy}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_noreq", {31'b0, mem_req}, 32'h0);
        end
        chk("hold_nreq", req_rises - base, 32'd1);
        fetch_en = 1'b0;
        tick();

        // PC control
        jump_en = 1'b1; jump_target = 32'h10;
        tick();
        jump_en = 1'b0;
        chk("pc_j10", pc, 32'h10);
        pc_inc = 1'b1;
        tick();
        pc_inc = 1'b0;
        chk("pc_inc14", pc, 32'h14);
        jump_en = 1'b1; pc_inc = 1'b1; jump_target = 32'h101;
        tick();
        jump_en = 1'b0; pc_inc = 1'b0;
        chk("pc_jprio", pc, 32'h100);
        jump_en = 1'b1; jump_target = 32'hFFFF_FFFC;
        tick();
        jump_en = 1'b0;
        chk("pc_top", pc, 32'hFFFF_FFFC);
        pc_inc = 1'b1;
        tick();
        pc_inc = 1'b0;
        chk("pc_wrap", pc, 32'h0);
        tick();
        chk("pc_hold", pc, 32'h0);

        // Stray ack in IDLE
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        chk("sidle_instr", instr, 32'h00a0_0093);
        chk("sidle_valid", {31'b0, instr_valid}, 32'h0);
        chk("sidle_req", {31'b0, mem_req}, 32'h0);

        // Stray ack in HOLD
        fetch_en = 1'b1;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        mem_ack = 1'b0;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        chk("shold_instr", instr, 32'h1111_1111);
        chk("shold_valid", {31'b0, instr_valid}, 32'h1);
        chk("shold_busy", {31'b0, fetch_busy}, 32'h0);
        chk("shold_req", {31'b0, mem_req}, 32'h0);
        fetch_en = 1'b0;
        tick();

        // Reset mid-request
        fetch_en = 1'b1;
        tick();
        chk("mr_req", {31'b0, mem_req}, 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("mr_req_async", {31'b0, mem_req}, 32'h0);
        chk("mr_instr", instr, 32'h13);
        fetch_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack = 1'b0;
        chk("mr_late_instr", instr, 32'h13);
        chk("mr_late_valid", {31'b0, instr_valid}, 32'h0);

        // Misaligned fetch
        jump_en = 1'b1; jump_target = 32'h102;
        tick();
        jump_en = 1'b0;
        chk("mis_pc", pc, 32'h102);
        base = req_rises;
        fetch_en = 1'b1;
        tick();
        chk("mis_fault", {31'b0, fetch_fault}, 32'h1);
        chk("mis_busy", {31'b0, fetch_busy}, 32'h1);
        chk("mis_req", {31'b0, mem_req}, 32'h0);
        fetch_en = 1'b0;
        tick(); tick(); tick();
        chk("mis_fault_st", {31'b0, fetch_fault}, 32'h1);
        chk("mis_busy_st", {31'b0, fetch_busy}, 32'h1);
        chk("mis_nreq", req_rises - base, 32'd0);
        reset = 1'b0;
        #1;
        chk("mis_rst_fault", {31'b0, fetch_fault}, 32'h0);
        chk("mis_rst_busy", {31'b0, fetch_busy}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage for the multicycle CPU. It sits directly upstream of the main controller and is driven by it.
- Holds the program counter and issues one instruction-memory read per controller FETCH state, tolerating variable memory latency.
- Latches the returned word into the instruction register that the controller and instruction decoder consume.
- Applies PC increment and jump updates requested by the controller, and raises a stall so the controller can hold its clock enable.

Parameters:
- XLEN, 32, width of PC, addresses and instruction word.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction register value after reset (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- fetch_en  input  1  controller fetch_en; high for the whole FETCH state.
- pc_inc  input  1  controller pc_inc; one-cycle pulse, PC += 4.
- jump_en  input  1  load PC from jump_target; one-cycle pulse.
- jump_target  input  XLEN  new PC for jump_en.
- mem_req  output  1  read request to instruction memory.
- mem_addr  output  XLEN  read address; stable while mem_req is high.
- mem_rdata  input  XLEN  read data; valid when mem_ack is high.
- mem_ack  input  1  read completion strobe; one cycle.
- instr  output  XLEN  instruction register, feeds the controller instr input.
- instr_valid  output  1  instr holds a word fetched for the current FETCH state.
- pc  output  XLEN  current PC.
- fetch_busy  output  1  combinational stall; controller ce must be low while high.
- fetch_fault  output  1  sticky misaligned-fetch flag.

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_PC, instr=NOP_INSTR, instr_valid=0, mem_req=0, mem_addr=0, fetch_fault=0, state=IDLE.
  - mem_req drops immediately, including mid-request.
  - An mem_ack arriving after reset release is ignored because the FSM is in IDLE.
- FSM states: IDLE, WAIT, HOLD, FAULT.
  - IDLE & fetch_en & pc[1:0]==0 → WAIT. Registers mem_addr=pc and sets mem_req=1 on that edge.
  - IDLE & fetch_en & pc[1:0]!=0 → FAULT. Sets fetch_fault=1; no request is issued.
  - WAIT & mem_ack → HOLD. Sets instr=mem_rdata, instr_valid=1, mem_req=0.
  - WAIT & !mem_ack → stay in WAIT with mem_req held high and mem_addr unchanged. There is no timeout.
  - HOLD & fetch_en → stay in HOLD; only one fetch is launched per FETCH state.
  - HOLD & !fetch_en → IDLE. instr_valid clears and instr retains its value.
  - FAULT: terminal until reset. fetch_busy=1 permanently, which stalls the core.
- mem_ack seen in IDLE or HOLD: ignored.
- fetch_busy = (state==IDLE & fetch_en) | state==WAIT | state==FAULT.
- Minimum fetch latency with zero-wait memory (mem_ack the cycle after mem_req rises): fetch_en rises, then 1 cycle to WAIT, then 1 cycle to HOLD, for 2 cycles of fetch_busy in total.
- PC update, evaluated every cycle in any FSM state:
  - jump_en has priority over pc_inc: pc = {jump_target[XLEN-1:1],1'b0}.
  - Otherwise pc_inc: pc = pc + 4, modulo 2^XLEN (0xFFFF_FFFC + 4 → 0x0000_0000).
  - Both low: pc unchanged.
  - An update during WAIT does not affect mem_addr of the in-flight request.
- instr is written only on mem_ack in WAIT. It is held through DECODE, EXECUTE and WRITEBACK.

Test Plan:
- Reset then zero-wait fetch: release reset with RESET_PC=0, drive fetch_en high. Mem returns 32'h0000_0037 (LUI) with ack one cycle after req. Required: mem_addr=0, fetch_busy high for exactly 2 cycles, instr=0x00000037, instr_valid=1, exactly one mem_req pulse.
- Wait states: mem_ack delayed 5 cycles. Required: mem_req and mem_addr held stable for 5 cycles and fetch_busy high throughout. Holding fetch_en high a further 3 cycles in HOLD issues no second request.
- PC control: pc_inc pulse from pc=0x10 gives 0x14. jump_en with target 0x101 and pc_inc high together gives pc=0x100. pc_inc at 0xFFFF_FFFC gives 0x0.
- Misaligned fetch: jump_target=0x102, then fetch_en. Required: mem_req never asserts, fetch_fault=1 and fetch_busy=1 until reset; reset clears both.
- Reset mid-request: assert reset while in WAIT. Required: mem_req=0 asynchronously and instr=0x00000013. A mem_ack driven after reset release leaves instr unchanged and instr_valid=0.
- Stray ack: pulse mem_ack in IDLE and in HOLD. Required: no change to instr, instr_valid or FSM state.
